mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. Decodes the held instruction, issues one
//  data-bus transaction per load/store, stalls the pipeline until the transaction completes,
//  then presents the extended load data to MEM/WB. The bus uses a req/gnt/rvalid handshake.
// PARAMETERS
//  TIMEOUT    16  max cycles in REQ+WAIT before the access aborts with m_bus_err
//  TIMEOUT_W   5  counter width; must satisfy 2**TIMEOUT_W > TIMEOUT
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  m_instr     in   32  instruction held in EX/MEM (opcode = [31:26])
//  m_addr      in   32  effective address (ALU result)
//  m_wdata     in   32  store data (rt, already forwarded)
//  m_adv       in   1   MEM/WB captures this cycle; M-stage instruction retires
//  m_stall     out  1   freeze PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB
//  m_ld_data   out  32  sign- or zero-extended load result; valid in DONE
//  m_bus_err   out  1   timeout or misaligned access (sticky until m_adv)
//  bus_req     out  1   request, registered
//  bus_we      out  1   1 = write
//  bus_addr    out  32  word-aligned address ({m_addr[31:2],2'b00})
//  bus_be      out  4   byte enables
//  bus_wdata   out  32  lane-shifted store data
//  bus_gnt     in   1   request accepted this cycle
//  bus_rvalid  in   1   read data valid (strictly after gnt)
//  bus_rdata   in   32  read data word
// BEHAVIOUR
//  - Decoded ops: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011,
//    sh 101001, sb 101000. Every other opcode is non-memory.
//  - FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//    IDLE: mem op present -> REQ. Non-memory instruction: stays IDLE, m_stall=0.
//    REQ:  bus_req=1; bus_gnt with a store -> DONE; bus_gnt with a load -> WAIT.
//    WAIT: bus_rvalid -> DONE, latch the extended data into m_ld_data.
//    DONE: m_stall=0; m_adv -> IDLE, and m_bus_err is cleared.
//  - m_stall = mem op present && state != DONE (combinational).
//  - Minimum latency: store 2 cycles stalled, load 3 cycles stalled (gnt and rvalid each at
//    the earliest cycle).
//  - Byte enables: sw 1111; sh 0011<<{a[1],0}; sb 0001<<a[1:0].
//    bus_wdata replicates the half/byte into every lane.
//  - Load extraction: lane selected by a[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
//  - Timeout counter: counts every cycle in REQ and WAIT and clears on entry to REQ.
//    Reaching TIMEOUT -> DONE with m_bus_err=1, m_ld_data=0, bus_req dropped.
//  - A simultaneous gnt and timeout: gnt wins.
//  - bus_addr, bus_we, bus_be and bus_wdata are stable while bus_req=1.
//  - Reset values: state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0,
//    m_ld_data=0, m_bus_err=0, counter=0.
//  - Reset mid-transaction: bus_req drops on the next edge and a late gnt or rvalid is ignored.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//    - Misaligned accesses never reach the bus: lw/sw with a[1:0]!=0, or lh/lhu/sh with a[0]=1.
//    - IDLE -> DONE directly; m_bus_err=1, m_ld_data=0, 1 stall cycle.
//  Undefined:
//    - Address low bits are used only for lane select; sw/lw ignore a[1:0].
// TESTING
//  1. sw a=0x10 d=0x12345678, gnt immediate
//     -> bus_be=1111, bus_wdata=0x12345678, m_stall high 2 cycles.
//  2. lb a=0x13, rdata=0x80FF0000, gnt and rvalid immediate
//     -> m_ld_data=0xFFFFFF80, stall 3 cycles; lbu -> 0x00000080.
//  3. sh a=0x06 d=0x0000BEEF -> bus_be=1100, bus_wdata=0xBEEFBEEF, bus_addr=0x04.
//  4. lw with gnt never asserted
//     -> m_bus_err=1 after TIMEOUT=16 cycles in REQ, m_ld_data=0, bus_req=0.
//  5. reset pulsed while in WAIT, rvalid next cycle
//     -> state IDLE, m_ld_data stays 0, bus_req=0.
//  6. MEM_MISALIGN_CHECK_EN, lw a=0x02 -> no bus_req, m_bus_err=1, stall 1 cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit.
// It decodes the instruction held in EX/MEM and issues one req/gnt/rvalid bus
// transaction for each load or store. The pipeline is stalled until that
// transaction completes. The extended load result is then presented to MEM/WB.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned lw/sw/lh/lhu/sh
// before they reach the bus. The default build leaves it out and uses the low
// address bits only as a lane select.
module mem_access_unit #(
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_adv,
  output logic        m_stall,
  output logic [31:0] m_ld_data,
  output logic        m_bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 is_load;
  logic                 is_store;
  logic                 mem_op;
  logic                 op_signed;
  logic [1:0]           op_size;
  logic                 misaligned;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 tmo_hit;
  logic [1:0]           ld_lane;
  logic [1:0]           ld_size;
  logic                 ld_signed;
  logic                 start_req;
  logic                 rd_done;
  logic                 tmo_abort;
  logic                 early_abort;
  logic                 retire;
  logic                 unused_instr;

  // Only the opcode field matters here; fold the rest away explicitly.
  assign unused_instr = ^m_instr[25:0];

  // Byte enables for an access of the given size starting at the given lane.
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'b0001 << lane;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated so that every lane carries the half/byte.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      SZ_WORD: wd = data;
      SZ_HALF: wd = {2{data[15:0]}};
      SZ_BYTE: wd = {4{data[7:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

  // Pick the addressed lane out of the read word and sign/zero extend it.
  function automatic logic [31:0] extract_load(input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [15:0] h16;
    logic [7:0]  b8;
    logic [31:0] res;
    h16 = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    b8 = word[7:0];
      2'd1:    b8 = word[15:8];
      2'd2:    b8 = word[23:16];
      2'd3:    b8 = word[31:24];
      default: b8 = word[7:0];
    endcase
    case (size)
      SZ_WORD: res = word;
      SZ_HALF: res = sgn ? {{16{h16[15]}}, h16} : {16'h0000, h16};
      SZ_BYTE: res = sgn ? {{24{b8[7]}}, b8} : {24'h000000, b8};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Classify the held instruction by opcode into load/store, size and signedness.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    op_size   = SZ_WORD;
    op_signed = 1'b0;
    case (m_instr[31:26])
      OP_LW:  begin is_load  = 1'b1; op_size = SZ_WORD; end
      OP_LH:  begin is_load  = 1'b1; op_size = SZ_HALF; op_signed = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; op_size = SZ_HALF; end
      OP_LB:  begin is_load  = 1'b1; op_size = SZ_BYTE; op_signed = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; op_size = SZ_BYTE; end
      OP_SW:  begin is_store = 1'b1; op_size = SZ_WORD; end
      OP_SH:  begin is_store = 1'b1; op_size = SZ_HALF; end
      OP_SB:  begin is_store = 1'b1; op_size = SZ_BYTE; end
      default: begin
        is_load  = 1'b0;
        is_store = 1'b0;
      end
    endcase
  end

  assign mem_op = is_load | is_store;

`ifdef MEM_MISALIGN_CHECK_EN
  // Flag word accesses off a word boundary and half accesses off a half boundary.
  always_comb begin
    case (op_size)
      SZ_WORD: misaligned = mem_op && (m_addr[1:0] != 2'b00);
      SZ_HALF: misaligned = mem_op && m_addr[0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // The counter keeps running in WAIT, so a late grant still expires promptly.
  assign tmo_hit = (tmo_cnt >= TIMEOUT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a grant beats the timeout, and read data beats it in WAIT.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (mem_op && misaligned) begin
          next_state = ST_DONE;
        end else if (mem_op) begin
          next_state = ST_REQ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          next_state = bus_we ? ST_DONE : ST_WAIT;
        end else if (tmo_hit) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid || tmo_hit) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (m_adv) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_DONE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output/event decode: the stall signal and the one-cycle events driving the datapath.
  always_comb begin
    m_stall     = mem_op && (state != ST_DONE);
    start_req   = 1'b0;
    rd_done     = 1'b0;
    tmo_abort   = 1'b0;
    early_abort = 1'b0;
    retire      = 1'b0;
    case (state)
      ST_IDLE: begin
        start_req   = mem_op && !misaligned;
        early_abort = mem_op && misaligned;
      end
      ST_REQ: begin
        tmo_abort = !bus_gnt && tmo_hit;
      end
      ST_WAIT: begin
        rd_done   = bus_rvalid;
        tmo_abort = !bus_rvalid && tmo_hit;
      end
      ST_DONE: begin
        retire = m_adv;
      end
      default: begin
        start_req = 1'b0;
      end
    endcase
  end

  // Datapath registers: bus request fields, the timeout counter, load result and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
      ld_lane   <= 2'b00;
      ld_size   <= SZ_WORD;
      ld_signed <= 1'b0;
      tmo_cnt   <= '0;
      m_ld_data <= 32'h0000_0000;
      m_bus_err <= 1'b0;
    end else begin
      // The request is high exactly while the FSM sits in REQ.
      bus_req <= (next_state == ST_REQ);
      // Capture the request on REQ entry so the fields stay fixed while req is high.
      if (start_req) begin
        bus_we    <= is_store;
        bus_addr  <= {m_addr[31:2], 2'b00};
        bus_be    <= lane_enables(op_size, m_addr[1:0]);
        bus_wdata <= lane_wdata(op_size, m_wdata);
        ld_lane   <= m_addr[1:0];
        ld_size   <= op_size;
        ld_signed <= op_signed;
      end
      if (start_req) begin
        tmo_cnt <= '0;
      end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      end
      if (rd_done) begin
        m_ld_data <= extract_load(ld_size, ld_signed, ld_lane, bus_rdata);
      end else if (tmo_abort || early_abort) begin
        m_ld_data <= 32'h0000_0000;
      end
      if (tmo_abort || early_abort) begin
        m_bus_err <= 1'b1;
      end else if (retire) begin
        m_bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit.
// Transactions are randomised and checked against a transaction-level model.
// The model predicts the stall length, the byte enables and lane data, the load
// result and any timeout/misalign error from the access rules and from the chosen
// gnt/rvalid delays.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int T = 16;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_instr, m_addr, m_wdata;
  logic        m_adv;
  logic        m_stall;
  logic [31:0] m_ld_data;
  logic        m_bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  mem_access_unit #(.TIMEOUT(16), .TIMEOUT_W(5)) dut (
    .clk(clk), .reset(reset),
    .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_adv(m_adv),
    .m_stall(m_stall), .m_ld_data(m_ld_data), .m_bus_err(m_bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [5:0] op_list [8] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_mem(input logic [5:0] op);
    bit hit = 1'b0;
    foreach (op_list[i]) if (op_list[i] == op) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic int op_bytes(input logic [5:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  // Predicted outcome of one transaction.
  int          e_stall;
  bit          e_err, e_bus, e_store;
  logic [31:0] e_ld, e_wdata, e_addr;
  logic [3:0]  e_be;

  task automatic predict(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int g, input int r);
    int nb, off, gk, rk;
    bit mis;
    logic [31:0] v;
    nb = op_bytes(op);
    off = (nb == 4) ? 0 : ((nb == 2) ? (a[1] ? 2 : 0) : int'(a[1:0]));
    e_store = is_store(op);
    e_addr = a & 32'hFFFF_FFFC;
    e_be = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) e_be[i] = 1'b1;
    for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    v = rd >> (8 * off);
    if (nb == 1) v = (op == OP_LB) ? {{24{v[7]}}, v[7:0]} : {24'h000000, v[7:0]};
    else if (nb == 2) v = (op == OP_LH) ? {{16{v[15]}}, v[15:0]} : {16'h0000, v[15:0]};
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (nb == 4 && a[1:0] != 2'b00) || (nb == 2 && a[0]);
`endif
    e_bus = !mis;
    gk = g + 1;
    rk = gk + r + 1;
    if (mis) begin
      e_stall = 1; e_err = 1'b1; e_ld = 32'h0;
    end else if (gk > T) begin
      e_stall = 1 + T; e_err = 1'b1; e_ld = 32'h0;
    end else if (e_store) begin
      e_stall = 1 + gk; e_err = 1'b0; e_ld = 32'h0;
    end else if (rk <= T || r == 0) begin
      e_stall = 1 + rk; e_err = 1'b0; e_ld = v;
    end else begin
      e_stall = 1 + ((gk + 1 > T) ? gk + 1 : T); e_err = 1'b1; e_ld = 32'h0;
    end
  endtask

  // Issue one memory instruction, act as the bus slave with the given delays and check it.
  // g = REQ cycles before gnt, r = WAIT cycles before rvalid.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
    int stalls, req_seen, w;
    bit granted, saw_req, done;
    predict(op, a, wd, rd, g, r);
    m_instr = {op, 26'($urandom)};
    m_addr = a; m_wdata = wd; bus_rdata = rd;
    m_adv = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1;
    stalls = 0; req_seen = 0; w = 0; granted = 1'b0; saw_req = 1'b0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (!m_stall) begin
        done = 1'b1;
        check({tag, ":stall"}, 32'(stalls), 32'(e_stall));
        check({tag, ":err"}, 32'(m_bus_err), 32'(e_err));
        check({tag, ":req_done"}, 32'(bus_req), 32'd0);
        check({tag, ":bus_used"}, 32'(saw_req), 32'(e_bus));
        if (!e_store || e_err) check({tag, ":ld"}, m_ld_data, e_ld);
        m_adv = 1'b1;
        @(posedge clk); @(negedge clk);
        m_adv = 1'b0;
        check({tag, ":err_clr"}, 32'(m_bus_err), 32'd0);
      end else begin
        stalls++;
        if (bus_req) begin
          saw_req = 1'b1;
          check({tag, ":req_ctl"}, {27'd0, bus_we, bus_be}, {27'd0, e_store, e_be});
          check({tag, ":req_addr"}, bus_addr, e_addr);
          if (e_store) check({tag, ":req_wdata"}, bus_wdata, e_wdata);
        end
        bus_gnt = bus_req && (req_seen == g);
        bus_rvalid = granted && !bus_req && !e_store && (w == r);
        if (bus_req) begin
          if (bus_gnt) granted = 1'b1;
          else req_seen++;
        end else if (granted) begin
          w++;
        end
        @(posedge clk); @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
      end
    end
    check({tag, ":finished"}, 32'(done), 32'd1);
  endtask

  task automatic nop_cycle(input string tag);
    logic [5:0] op;
    op = 6'($urandom);
    if (is_mem(op)) op = 6'h00;
    m_instr = {op, 26'($urandom)};
    m_adv = 1'b1;
    #1;
    check({tag, ":nop_stall"}, 32'(m_stall), 32'd0);
    @(posedge clk); @(negedge clk);
    check({tag, ":nop_req"}, 32'(bus_req), 32'd0);
    m_adv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, r;
    reset = 1'b1; m_instr = 32'h0; m_addr = 32'h0; m_wdata = 32'h0; m_adv = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:req", 32'(bus_req), 32'd0);
    check("rst:we_be", {27'd0, bus_we, bus_be}, 32'd0);
    check("rst:addr", bus_addr, 32'd0);
    check("rst:wdata", bus_wdata, 32'd0);
    check("rst:ld", m_ld_data, 32'd0);
    check("rst:err", 32'(m_bus_err), 32'd0);
    check("rst:stall", 32'(m_stall), 32'd0);
    reset = 1'b0;

    run_op("sw_basic", OP_SW, 32'h10, 32'h12345678, 32'h0, 0, 0);
    run_op("lb_sext", OP_LB, 32'h13, 32'h0, 32'h80FF0000, 0, 0);
    run_op("lbu_zext", OP_LBU, 32'h13, 32'h0, 32'h80FF0000, 0, 0);
    run_op("sh_hi", OP_SH, 32'h06, 32'h0000BEEF, 32'h0, 0, 0);
    run_op("lw_nognt", OP_LW, 32'h20, 32'h0, 32'hCAFEF00D, 100, 0);
    run_op("sw_gnt16", OP_SW, 32'h24, 32'hA5A5A5A5, 32'h0, 15, 0);
    run_op("sw_gnt17", OP_SW, 32'h28, 32'h5A5A5A5A, 32'h0, 16, 0);
    run_op("lw_gnt16", OP_LW, 32'h2C, 32'h0, 32'h01234567, 15, 0);
    run_op("lw_rv_late", OP_LW, 32'h30, 32'h0, 32'h89ABCDEF, 3, 20);
    run_op("lh_gnt16_late", OP_LH, 32'h34, 32'h0, 32'hFFFF8001, 15, 2);
    run_op("lh_neg", OP_LH, 32'h36, 32'h0, 32'h8001FFFF, 1, 2);
`ifdef MEM_MISALIGN_CHECK_EN
    run_op("lw_mis", OP_LW, 32'h02, 32'h0, 32'h11111111, 0, 0);
    run_op("sh_mis", OP_SH, 32'h01, 32'h1234, 32'h0, 0, 0);
`endif

    // Reset while waiting for read data; the late rvalid must be ignored.
    m_instr = {OP_LW, 26'h0}; m_addr = 32'h40; bus_rdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    check("rstw:req", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_gnt = 1'b0;
    check("rstw:wait_stall", 32'(m_stall), 32'd1);
    check("rstw:wait_req", 32'(bus_req), 32'd0);
    reset = 1'b1; m_instr = 32'h0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; bus_rvalid = 1'b1;
    #1;
    check("rstw:req0", 32'(bus_req), 32'd0);
    check("rstw:ld0", m_ld_data, 32'd0);
    check("rstw:stall0", 32'(m_stall), 32'd0);
    @(posedge clk); @(negedge clk);
    bus_rvalid = 1'b0;
    check("rstw:ld1", m_ld_data, 32'd0);
    check("rstw:req1", 32'(bus_req), 32'd0);
    check("rstw:err1", 32'(m_bus_err), 32'd0);
    run_op("post_rst_sw", OP_SW, 32'h44, 32'h0BADF00D, 32'h0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        g = $urandom_range(13, 17);
        r = $urandom_range(0, 20);
      end else begin
        g = $urandom_range(0, 3);
        r = $urandom_range(0, 3);
      end
      run_op("rand", op_list[$urandom_range(0, 7)], $urandom, $urandom, $urandom, g, r);
      if ($urandom_range(0, 2) == 0) nop_cycle("rand");
    end

    m_instr = 32'h0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
